full_adder_reg: RTL and testbench

Single-bit full adder with a purely combinational sum/carry path and an optional clocked output stage. The stage provides registered copies of the result and a saturating carry-event counter. It is the leaf arithmetic cell for ripple-carry datapaths. It can also be dropped standalone into a bench using the 5-port positional form, since the combinational outputs do not depend on clock or reset.

---
 rtl/full_adder_reg.sv | 72 +++++++
 tb/tb_full_adder_reg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/full_adder_reg.sv
// Single-bit full adder with an optional registered output stage and saturating carry-event counter.
// Define FULL_ADDER_REG_OUT_EN to build the registered stage; otherwise the outputs are combinational ties.
module full_adder_reg #(
  parameter int CNT_W = 8
) (
  input  logic             a,
  input  logic             b,
  input  logic             C_in,
  output logic             Sum,
  output logic             C_out,
  input  logic             clk,
  input  logic             rst,
  output logic             Sum_q,
  output logic             C_out_q,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             cnt_sat
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign Sum     = a_xor_b ^ C_in;
  assign C_out   = (a & b) | (C_in & a_xor_b);

`ifdef FULL_ADDER_REG_OUT_EN

  logic             sum_r_q;
  logic             cout_r_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sat;

  assign sat = &cnt_q;

  // Counter holds at all ones instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (C_out && !sat) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r_q  <= 1'b0;
      cout_r_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sum_r_q  <= Sum;
      cout_r_q <= C_out;
      cnt_q    <= cnt_d;
    end
  end

  assign Sum_q     = sum_r_q;
  assign C_out_q   = cout_r_q;
  assign carry_cnt = cnt_q;
  assign cnt_sat   = sat;

`else

  logic unused_clk_rst;

  assign unused_clk_rst = &{1'b0, clk, rst};
  assign Sum_q          = Sum;
  assign C_out_q        = C_out;
  assign carry_cnt      = '0;
  assign cnt_sat        = 1'b0;

`endif

endmodule

// File: tb/tb_full_adder_reg.sv
// Directed self-checking bench for full_adder_reg; expectations follow FULL_ADDER_REG_OUT_EN.
module tb_full_adder_reg;

`ifdef FULL_ADDER_REG_OUT_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic       a;
  logic       b;
  logic       c_in;
  logic       sum8;
  logic       cout8;
  logic       sum_q8;
  logic       cout_q8;
  logic [7:0] cnt8;
  logic       sat8;
  logic       sum2;
  logic       cout2;
  logic       sum_q2;
  logic       cout_q2;
  logic [1:0] cnt2;
  logic       sat2;

  int checks = 0;
  int errors = 0;

  full_adder_reg #(.CNT_W(8)) dut8 (
    .a(a), .b(b), .C_in(c_in), .Sum(sum8), .C_out(cout8),
    .clk(clk), .rst(rst), .Sum_q(sum_q8), .C_out_q(cout_q8),
    .carry_cnt(cnt8), .cnt_sat(sat8)
  );

  full_adder_reg #(.CNT_W(2)) dut2 (
    .a(a), .b(b), .C_in(c_in), .Sum(sum2), .C_out(cout2),
    .clk(clk), .rst(rst), .Sum_q(sum_q2), .C_out_q(cout_q2),
    .carry_cnt(cnt2), .cnt_sat(sat2)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] abc);
    a    = abc[2];
    b    = abc[1];
    c_in = abc[0];
  endtask

  logic [2:0] tv   [8];
  logic [1:0] tv_e [8];
  logic [1:0] sat_seq_cnt [5];
  logic       sat_seq_flag [5];

  initial begin
    tv[0] = 3'b000; tv_e[0] = 2'b00;
    tv[1] = 3'b100; tv_e[1] = 2'b01;
    tv[2] = 3'b010; tv_e[2] = 2'b01;
    tv[3] = 3'b001; tv_e[3] = 2'b01;
    tv[4] = 3'b110; tv_e[4] = 2'b10;
    tv[5] = 3'b011; tv_e[5] = 2'b10;
    tv[6] = 3'b101; tv_e[6] = 2'b10;
    tv[7] = 3'b111; tv_e[7] = 2'b11;
    sat_seq_cnt[0] = 2'd1; sat_seq_flag[0] = 1'b0;
    sat_seq_cnt[1] = 2'd2; sat_seq_flag[1] = 1'b0;
    sat_seq_cnt[2] = 2'd3; sat_seq_flag[2] = 1'b1;
    sat_seq_cnt[3] = 2'd3; sat_seq_flag[3] = 1'b1;
    sat_seq_cnt[4] = 2'd3; sat_seq_flag[4] = 1'b1;

    clk_en = 1'b0;
    rst    = 1'b1;
    drive(3'b000);
    #10;
    check("reset_sum_q",   sum_q8,  0);
    check("reset_cout_q",  cout_q8, 0);
    check("reset_cnt",     cnt8,    0);
    check("reset_sat",     sat8,    0);

    // Truth table with the clock idle; registered outputs stay in reset when built
    for (int i = 0; i < 8; i++) begin
      drive(tv[i]);
      #10;
      check($sformatf("tt_sum_%0d", i),  sum8,  tv_e[i][0]);
      check($sformatf("tt_cout_%0d", i), cout8, tv_e[i][1]);
      check($sformatf("tt_sum_w2_%0d", i),  sum2,  tv_e[i][0]);
      check($sformatf("tt_cout_w2_%0d", i), cout2, tv_e[i][1]);
      check($sformatf("tt_sum_q_%0d", i),  sum_q8,  REG_EN ? 1'b0 : tv_e[i][0]);
      check($sformatf("tt_cout_q_%0d", i), cout_q8, REG_EN ? 1'b0 : tv_e[i][1]);
      check($sformatf("tt_cnt_%0d", i), cnt8, 0);
    end

    drive(3'b000);
    #2;
    rst    = 1'b0;
    clk_en = 1'b1;
    tick();
    check("first_edge_cnt",   cnt8,   0);
    check("first_edge_sum_q", sum_q8, 0);

    drive(3'b111);
    #1;
    check("latency_sum_q_before",  sum_q8,  REG_EN ? 1'b0 : 1'b1);
    check("latency_cout_q_before", cout_q8, REG_EN ? 1'b0 : 1'b1);
    tick();
    check("latency_sum_q_after",  sum_q8,  1);
    check("latency_cout_q_after", cout_q8, 1);
    check("latency_cnt",          cnt8,    REG_EN ? 16'd1 : 16'd0);
    tick();
    tick();
    check("carry_cnt_3",  cnt8, REG_EN ? 16'd3 : 16'd0);
    check("sat_w2_early", sat2, REG_EN ? 1'b1 : 1'b0);
    check("sat_w8_clear", sat8, 0);

    // Mid-cycle reset pulse: clears the stage without a clock edge
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_sum_q",  sum_q8,  REG_EN ? 1'b0 : 1'b1);
    check("async_rst_cout_q", cout_q8, REG_EN ? 1'b0 : 1'b1);
    check("async_rst_cnt",    cnt8,    0);
    check("async_rst_cnt_w2", cnt2,    0);
    check("async_rst_sat_w2", sat2,    0);
    #1;
    rst = 1'b0;

    drive(3'b110);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat_cnt_w2_%0d", i),  cnt2, REG_EN ? sat_seq_cnt[i] : 2'd0);
      check($sformatf("sat_flag_w2_%0d", i), sat2, REG_EN ? sat_seq_flag[i] : 1'b0);
      check($sformatf("sat_cnt_w8_%0d", i),  cnt8, REG_EN ? 8'(i + 1) : 8'd0);
    end
    check("sat_hold_sum_q",  sum_q2,  0);
    check("sat_hold_cout_q", cout_q2, 1);

    drive(3'b100);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("nocarry_cnt_w8_%0d", i), cnt8,   REG_EN ? 16'd5 : 16'd0);
      check($sformatf("nocarry_cnt_w2_%0d", i), cnt2,   REG_EN ? 16'd3 : 16'd0);
      check($sformatf("nocarry_sum_q_%0d", i),  sum_q8, 1);
      check($sformatf("nocarry_cout_q_%0d", i), cout_q8, 0);
    end
    check("nocarry_sum",  sum8,  1);
    check("nocarry_cout", cout8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
